// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- VGA raster timing generator.
//
// Divides clk down to a pixel tick and walks a (hCount, vCount) raster.
// Video qualifiers (bright, hSync, vSync) are registered on the pixel tick
// from the next counter values, so they line up with hCount/vCount.
//
// Ports:
//   clk         system clock
//   clr         asynchronous active-high reset
//   pixelEn     one-clk pulse per pixel tick (decode of divider)
//   hCount      horizontal position, 0..H_TOTAL-1
//   vCount      vertical position, 0..V_TOTAL-1
//   bright      high inside the visible region
//   hSync/vSync active-low sync pulses
//   VGA_CLK     pixel clock to the DAC, rising mid-pixel
//   VGA_BLANK_N copy of bright
//   VGA_SYNC_N  constant 0 (no sync-on-green)
//   lineStart   one-clk pulse after hCount wraps to 0
//   frameStart  one-clk pulse after (hCount,vCount) wraps to (0,0)
//
// Optional build macro VGA_SYNC_DELAY_EN: bright/hSync/vSync (and
// VGA_BLANK_N) pass through a SYNC_DELAY-stage pipe advanced on pixelEn,
// matching downstream tile-memory read latency. Counters stay undelayed.

module vga_timing_gen #(
  parameter int CLK_DIV    = 2,
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic        clk,
  input  logic        clr,
  output logic        pixelEn,
  output logic [15:0] hCount,
  output logic [15:0] vCount,
  output logic        bright,
  output logic        hSync,
  output logic        vSync,
  output logic        VGA_CLK,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic        lineStart,
  output logic        frameStart
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_VIS    = 16'(H_VISIBLE);
  localparam logic [15:0] V_VIS    = 16'(V_VISIBLE);
  localparam logic [15:0] HS_START = 16'(H_VISIBLE + H_FRONT);
  localparam logic [15:0] HS_END   = 16'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [15:0] VS_START = 16'(V_VISIBLE + V_FRONT);
  localparam logic [15:0] VS_END   = 16'(V_VISIBLE + V_FRONT + V_SYNC);

  // Elaboration-time guard on the divider and delay-line depth.
  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0 || SYNC_DELAY < 1) begin : gBadParam
    $error("vga_timing_gen: CLK_DIV must be even and >= 2, SYNC_DELAY >= 1");
  end

  typedef struct packed {
    logic bright;
    logic hSync;
    logic vSync;
  } qual_t;

  localparam qual_t QUAL_IDLE = '{bright: 1'b0, hSync: 1'b1, vSync: 1'b1};

  logic [DIV_W-1:0] div, divNext;
  logic [15:0]      hNext, vNext;
  logic             hWrap, vWrap;
  qual_t            qualNext, qualRaw, qualOut;

  // ---------------- divider ----------------
  assign pixelEn = (div == DIV_LAST);
  assign divNext = pixelEn ? '0 : div + DIV_W'(1);

  // ---------------- next raster position ----------------
  assign hWrap = (hCount == H_LAST);
  assign vWrap = (vCount == V_LAST);

  always_comb begin
    hNext = hCount + 16'd1;
    vNext = vCount;
    if (hWrap) begin
      hNext = '0;
      vNext = vWrap ? '0 : vCount + 16'd1;
    end
  end

  // Qualifiers computed from the position being loaded, so after the
  // tick they describe the pixel hCount/vCount now point at.
  always_comb begin
    qualNext.bright = (hNext < H_VIS) && (vNext < V_VIS);
    qualNext.hSync  = !((hNext >= HS_START) && (hNext < HS_END));
    qualNext.vSync  = !((vNext >= VS_START) && (vNext < VS_END));
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      div        <= '0;
      VGA_CLK    <= 1'b0;
      hCount     <= '0;
      vCount     <= '0;
      qualRaw    <= QUAL_IDLE;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      div        <= divNext;
      // Registered from the next divider value: low for the first half of
      // each pixel, so the DAC's rising edge lands mid-pixel.
      VGA_CLK    <= (divNext >= DIV_HALF);
      lineStart  <= pixelEn && hWrap;
      frameStart <= pixelEn && hWrap && vWrap;
      if (pixelEn) begin
        hCount  <= hNext;
        vCount  <= vNext;
        qualRaw <= qualNext;
      end
    end
  end

  // ---------------- optional qualifier delay line ----------------
`ifdef VGA_SYNC_DELAY_EN
  qual_t [SYNC_DELAY-1:0] qualPipe;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      qualPipe <= {SYNC_DELAY{QUAL_IDLE}};
    end else if (pixelEn) begin
      for (int i = SYNC_DELAY - 1; i > 0; i--) qualPipe[i] <= qualPipe[i-1];
      qualPipe[0] <= qualRaw;
    end
  end

  assign qualOut = qualPipe[SYNC_DELAY-1];
`else
  assign qualOut = qualRaw;
`endif

  assign bright      = qualOut.bright;
  assign hSync       = qualOut.hSync;
  assign vSync       = qualOut.vSync;
  assign VGA_BLANK_N = qualOut.bright;
  assign VGA_SYNC_N  = 1'b0;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator sitting directly upstream of the glyph/bit generator.
- Divides the system clock down to a pixel tick and runs 16-bit horizontal and vertical counters.
- Drives hCount, vCount and bright to the bit generator.
- Drives hSync, vSync, VGA_CLK, VGA_BLANK_N and VGA_SYNC_N to the DAC.
- Emits per-line and per-frame strobes for game-logic updates during blanking.

Parameters:
CLK_DIV, 2, system clocks per pixel; even, ≥2 (50 MHz → 25 MHz)
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch pixels
H_SYNC, 96, horizontal sync pulse pixels
H_BACK, 48, horizontal back porch pixels
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch lines
V_SYNC, 2, vertical sync pulse lines
V_BACK, 33, vertical back porch lines
SYNC_DELAY, 1, pixel ticks of delay on video-qualifier outputs (only used with the optional feature)

Ports:
clk  in  1  system clock
clr  in  1  reset; asynchronous, active-high
pixelEn  out  1  one-clk pulse marking each pixel tick
hCount  out  16  horizontal position, 0..H_TOTAL-1
vCount  out  16  vertical position, 0..V_TOTAL-1
bright  out  1  high inside the visible region
hSync  out  1  horizontal sync, active-low
vSync  out  1  vertical sync, active-low
VGA_CLK  out  1  pixel clock to the DAC
VGA_BLANK_N  out  1  equals bright
VGA_SYNC_N  out  1  tied 0 (no sync-on-green)
lineStart  out  1  one-clk pulse when hCount wraps to 0
frameStart  out  1  one-clk pulse when (hCount,vCount) wraps to (0,0)

Behaviour:
- Derived constants: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Reset (clr=1, asynchronous, takes effect immediately, including mid-frame) clears:
  - divider, hCount, vCount to 0;
  - bright, VGA_CLK, pixelEn, lineStart, frameStart to 0;
  - hSync, vSync to 1;
  - all delay-line stages to their inactive values (bright 0, syncs 1).
  - On clr release, counting restarts from (0,0) with no frameStart pulse for that first frame.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - pixelEn=1 (combinational decode of the register) exactly when divider==CLK_DIV-1.
  - VGA_CLK is registered: 1 when the divider is ≥ CLK_DIV/2, so its rising edge falls mid-pixel.
- Counters advance only on a clk edge with pixelEn=1:
  - hCount==H_TOTAL-1 → hCount=0 and vCount increments.
  - Otherwise hCount increments.
  - vCount==V_TOTAL-1 at end of line → vCount=0.
  - Upper counter bits are always 0.
- Video qualifiers are registered and updated on the same edge as the counters, computed from the next counter values, so they are coincident with hCount/vCount:
  - bright = (hCount < H_VISIBLE) && (vCount < V_VISIBLE).
  - hSync = 0 iff H_VISIBLE+H_FRONT ≤ hCount < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vSync = 0 iff V_VISIBLE+V_FRONT ≤ vCount < V_VISIBLE+V_FRONT+V_SYNC (490..491).
- Strobes:
  - lineStart: high for exactly one clk, in the clk cycle immediately after the edge that loads hCount=0.
  - frameStart: high under the same rule, only when vCount is also loaded to 0.
  - frameStart therefore always coincides with a lineStart.
- Relative latency: counters and all qualifiers update together, every CLK_DIV clocks, with zero relative skew.

Optional Feature:
- Macro: VGA_SYNC_DELAY_EN.
- Defined:
  - bright, hSync, vSync and VGA_BLANK_N pass through a SYNC_DELAY-stage shift register clocked on pixelEn.
  - hCount and vCount stay undelayed.
  - This aligns the qualifiers with the downstream tile-memory read latency.
  - Stages reset to their inactive values.
- Undefined:
  - No delay stages; qualifiers are coincident with the counters.
  - SYNC_DELAY is ignored.

Test Plan:
- Assert clr for 3 clks, release → hCount=0, vCount=0, hSync=1, vSync=1, bright=1 after the first pixel tick; pixelEn pulses every 2nd clk.
- Run one line → hCount 639→640 drops bright; hSync=0 for hCount 656..751 (96 ticks); at 799→0 vCount increments and lineStart pulses for 1 clk.
- Run a full frame → vSync=0 only for vCount 490..491; wrap from (799,524) to (0,0) pulses frameStart and lineStart for exactly 1 clk; frame length 800×525×2 = 840000 clks.
- Assert clr mid-frame at (300,200) for 1 clk asynchronously → outputs clear immediately, not waiting for a clk edge; counting resumes from (0,0).
- With VGA_SYNC_DELAY_EN and SYNC_DELAY=2 → bright falls 2 pixel ticks after hCount reaches 640; hSync falls at hCount=658; hCount itself is unchanged vs the non-macro build.
- Check VGA_CLK → 25 MHz square wave, rising edge 1 clk after each counter update; VGA_SYNC_N constant 0.
